// File: rtl/wb_cpu_bus_arbiter.sv
// Round-robin, cycle-atomic arbiter merging the CPU instruction and data Wishbone B3 masters onto one port.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_cpu_bus_arbiter #(
    parameter int          ADDRESS_WIDTH  = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] iwbm_adr_i,
    input  logic [DATA_WIDTH-1:0]    iwbm_dat_i,
    input  logic                     iwbm_cyc_i,
    input  logic                     iwbm_stb_i,
    input  logic                     iwbm_we_i,
    input  logic [3:0]               iwbm_sel_i,
    input  logic [2:0]               iwbm_cti_i,
    input  logic [1:0]               iwbm_bte_i,
    output logic [DATA_WIDTH-1:0]    iwbm_dat_o,
    output logic                     iwbm_ack_o,
    output logic                     iwbm_err_o,
    output logic                     iwbm_rty_o,
    input  logic [ADDRESS_WIDTH-1:0] dwbm_adr_i,
    input  logic [DATA_WIDTH-1:0]    dwbm_dat_i,
    input  logic                     dwbm_cyc_i,
    input  logic                     dwbm_stb_i,
    input  logic                     dwbm_we_i,
    input  logic [3:0]               dwbm_sel_i,
    input  logic [2:0]               dwbm_cti_i,
    input  logic [1:0]               dwbm_bte_i,
    output logic [DATA_WIDTH-1:0]    dwbm_dat_o,
    output logic                     dwbm_ack_o,
    output logic                     dwbm_err_o,
    output logic                     dwbm_rty_o,
    output logic [ADDRESS_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0]    wbm_dat_o,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [3:0]               wbm_sel_o,
    output logic [2:0]               wbm_cti_o,
    output logic [1:0]               wbm_bte_o,
    input  logic [DATA_WIDTH-1:0]    wbm_dat_i,
    input  logic                     wbm_ack_i,
    input  logic                     wbm_err_i,
    input  logic                     wbm_rty_i,
    output logic [1:0]               wbm_gnt_o
);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: D won the most recent tie
    logic   own_i, own_d;
    logic   flushing, tmo_fire, blocked;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    assign own_i     = (state_q == OWN_I);
    assign own_d     = (state_q == OWN_D);
    assign blocked   = flushing | tmo_fire;
    assign wbm_gnt_o = {own_d, own_i};

    // last_d only moves on a tie, so a lone request does not disturb the rotation
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (iwbm_cyc_i && dwbm_cyc_i) begin
                    state_d  = last_d_q ? OWN_I : OWN_D;
                    last_d_d = !last_d_q;
                end else if (dwbm_cyc_i) begin
                    state_d = OWN_D;
                end else if (iwbm_cyc_i) begin
                    state_d = OWN_I;
                end
            end
            OWN_I:   if (!iwbm_cyc_i) state_d = IDLE;
            OWN_D:   if (!dwbm_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       flushing_q, flushing_d;
    logic       owner_stb, grant, resp_any;

    assign owner_stb = (own_i & iwbm_stb_i) | (own_d & dwbm_stb_i);
    assign grant     = (state_q == IDLE) && (iwbm_cyc_i || dwbm_cyc_i);
    assign resp_any  = (own_i | own_d) & (wbm_ack_i | wbm_err_i | wbm_rty_i);
    assign flushing  = flushing_q;
    assign tmo_fire  = owner_stb && !flushing_q && (tmo_cnt_q == TMO_LIMIT);

    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        flushing_d = flushing_q;
        if (grant || resp_any)
            tmo_cnt_d = '0;
        else if (owner_stb && !flushing_q && !tmo_fire)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (state_d == IDLE)
            flushing_d = 1'b0;
        else if (tmo_fire)
            flushing_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q  <= '0;
            flushing_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            flushing_q <= flushing_d;
        end
    end
`else
    assign flushing = 1'b0;
    assign tmo_fire = 1'b0;
`endif

    assign iwbm_dat_o = wbm_dat_i;
    assign dwbm_dat_o = wbm_dat_i;

    always_comb begin
        wbm_adr_o  = '0;
        wbm_dat_o  = '0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = '0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        iwbm_ack_o = 1'b0;
        iwbm_err_o = 1'b0;
        iwbm_rty_o = 1'b0;
        dwbm_ack_o = 1'b0;
        dwbm_err_o = 1'b0;
        dwbm_rty_o = 1'b0;
        if (own_i) begin
            wbm_adr_o  = iwbm_adr_i;
            wbm_dat_o  = iwbm_dat_i;
            wbm_cyc_o  = iwbm_cyc_i & ~blocked;
            wbm_stb_o  = iwbm_stb_i & ~blocked;
            wbm_we_o   = iwbm_we_i;
            wbm_sel_o  = iwbm_sel_i;
            wbm_cti_o  = iwbm_cti_i;
            wbm_bte_o  = iwbm_bte_i;
            iwbm_ack_o = wbm_ack_i & ~blocked;
            iwbm_err_o = tmo_fire | (wbm_err_i & ~blocked);
            iwbm_rty_o = wbm_rty_i & ~blocked;
        end else if (own_d) begin
            wbm_adr_o  = dwbm_adr_i;
            wbm_dat_o  = dwbm_dat_i;
            wbm_cyc_o  = dwbm_cyc_i & ~blocked;
            wbm_stb_o  = dwbm_stb_i & ~blocked;
            wbm_we_o   = dwbm_we_i;
            wbm_sel_o  = dwbm_sel_i;
            wbm_cti_o  = dwbm_cti_i;
            wbm_bte_o  = dwbm_bte_i;
            dwbm_ack_o = wbm_ack_i & ~blocked;
            dwbm_err_o = tmo_fire | (wbm_err_i & ~blocked);
            dwbm_rty_o = wbm_rty_i & ~blocked;
        end
    end

endmodule
